// File: rtl/usart_pkg.sv
// usart_pkg: usart_ctrl command codes and transmit scheduler state encoding.
package usart_pkg;
  localparam logic [2:0] USART_CMD_NOP  = 3'd0;
  localparam logic [2:0] USART_CMD_CFG  = 3'd1;
  localparam logic [2:0] USART_CMD_TX   = 3'd2;
  localparam logic [2:0] USART_CMD_RX   = 3'd3;
  localparam logic [2:0] USART_CMD_STAT = 3'd4;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} tx_state_t;
endpackage

// File: rtl/usart_tx_sched_if.sv
// usart_tx_sched_if: requester handshakes, usart_ctrl strobe/busy and status of the TX scheduler.
interface usart_tx_sched_if #(parameter int DEPTH = 4);
  logic                    req0_valid;
  logic [7:0]              req0_data;
  logic                    req0_ready;
  logic                    req1_valid;
  logic [7:0]              req1_data;
  logic                    req1_ready;
  logic                    usart_write;
  logic [2:0]              usart_cmd;
  logic [7:0]              usart_data;
  logic                    usart_busy;
  logic [$clog2(DEPTH):0]  fifo_level;
  logic                    timeout_err;
  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, usart_busy,
    input  req0_ready, req1_ready, usart_write, usart_cmd, usart_data, fifo_level, timeout_err
  );
  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, usart_busy,
    output req0_ready, req1_ready, usart_write, usart_cmd, usart_data, fifo_level, timeout_err
  );
endinterface

// File: rtl/sync_byte_fifo.sv
// sync_byte_fifo: single-clock byte FIFO with show-ahead head and occupancy level.
module sync_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [7:0]             push_data,
  input  logic                   pop,
  output logic [7:0]             pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  assign full     = level == (AW+1)'(DEPTH);
  assign empty    = level == '0;
  assign pop_data = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push != pop) level <= push ? level + 1'b1 : level - 1'b1;
    end
  end
endmodule

// File: rtl/usart_tx_sched.sv
// usart_tx_sched: round-robin merge of two byte sources into a FIFO that feeds usart_ctrl one byte per busy handshake.
module usart_tx_sched
  import usart_pkg::*;
#(
  parameter int         DEPTH       = 4,
  parameter int         ACK_TIMEOUT = 15,
  parameter logic [2:0] TX_CMD      = USART_CMD_TX
) (
  input  logic            clk,
  input  logic            reset,
  usart_tx_sched_if.slave bus
);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  tx_state_t              state;
  logic                   rr;
  logic                   pop;
  logic                   can_push;
  logic                   gnt0;
  logic                   gnt1;
  logic                   full;
  logic                   empty;
  logic [7:0]             head;
  logic [$clog2(DEPTH):0] level;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          cnt_nxt;
  logic                   write;
  logic [2:0]             cmd;
  logic [7:0]             data;
  logic                   err;
  // a full FIFO still accepts a byte in the cycle the FSM pops its head
  always_comb begin
    pop      = state == IDLE && !empty;
    can_push = !reset && (!full || pop);
    gnt0     = can_push && bus.req0_valid && (!bus.req1_valid || !rr);
    gnt1     = can_push && bus.req1_valid && !gnt0;
    cnt_nxt  = cnt + 1'b1;
  end
  sync_byte_fifo #(.DEPTH(DEPTH)) fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (gnt0 || gnt1),
    .push_data (gnt0 ? bus.req0_data : bus.req1_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );
  // rr names the requester that wins the next tie; the strobe is registered so it lands in ISSUE
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rr    <= 1'b0;
      write <= 1'b0;
      cmd   <= '0;
      data  <= '0;
      err   <= 1'b0;
      cnt   <= '0;
    end else begin
      if (gnt0 || gnt1) rr <= gnt0;
      write <= pop;
      case (state)
        IDLE: if (!empty) begin
          data  <= head;
          cmd   <= TX_CMD;
          state <= ISSUE;
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT_ACK;
        end
        WAIT_ACK: if (bus.usart_busy) state <= WAIT_DONE;
        else begin
          cnt <= cnt_nxt;
          if (cnt_nxt == CW'(ACK_TIMEOUT)) begin
            err   <= 1'b1;
            state <= IDLE;
          end
        end
        WAIT_DONE: if (!bus.usart_busy) state <= IDLE;
      endcase
    end
  end
  assign bus.req0_ready  = gnt0;
  assign bus.req1_ready  = gnt1;
  assign bus.usart_write = write;
  assign bus.usart_cmd   = cmd;
  assign bus.usart_data  = data;
  assign bus.fifo_level  = level;
  assign bus.timeout_err = err;
endmodule
